// File: rtl/icache_assoc_pkg.sv
// Shared types for the set-associative instruction cache.
package icache_assoc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Width of an index able to select one of n items (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_lru.sv
// Per-set age storage for LRU replacement and victim selection.
// Age 0 is the most recently used way. A way being filled is treated as the
// oldest, so the ages of a fully valid set always form a permutation.
module icache_assoc_lru
    import icache_assoc_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    parameter int IXW  = 3,
    parameter int WW   = 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [IXW-1:0]  set_idx,
    input  logic [WAYS-1:0] set_valid,
    input  logic [WW-1:0]   way_idx,
    input  logic            update,
    output logic [WW-1:0]   victim_way
);

    generate
        if (WAYS > 1) begin : g_age
            logic [WW-1:0] age_r [SETS][WAYS];
            logic [WW-1:0] old_age_s;
            logic [WW-1:0] victim_s;
            logic          found_s;

            // Reference age of the accessed way; an invalid way counts as oldest.
            always_comb begin
                old_age_s = WW'(WAYS - 1);
                if (set_valid[way_idx]) begin
                    old_age_s = age_r[set_idx][way_idx];
                end else begin
                    old_age_s = WW'(WAYS - 1);
                end
            end

            // Age update: accessed way becomes youngest, younger ways age by one.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            age_r[s][w] <= '0;
                        end
                    end
                end else if (update) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (w == int'(way_idx)) begin
                            age_r[set_idx][w] <= '0;
                        end else if (age_r[set_idx][w] < old_age_s) begin
                            age_r[set_idx][w] <= age_r[set_idx][w] + WW'(1);
                        end
                    end
                end
            end

            // Victim: lowest invalid way, otherwise the way holding the oldest age.
            always_comb begin
                victim_s = '0;
                found_s  = 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    if (!found_s && !set_valid[w]) begin
                        victim_s = WW'(w);
                        found_s  = 1'b1;
                    end else begin
                        found_s  = found_s;
                    end
                end
                for (int w = 0; w < WAYS; w++) begin
                    if (!found_s && (age_r[set_idx][w] == WW'(WAYS - 1))) begin
                        victim_s = WW'(w);
                        found_s  = 1'b1;
                    end else begin
                        found_s  = found_s;
                    end
                end
            end

            assign victim_way = victim_s;
        end else begin : g_single
            logic unused_s;
            assign unused_s   = ^{CLK, nRST, set_idx, set_valid, way_idx, update};
            assign victim_way = '0;
        end
    endgenerate

endmodule

// File: rtl/icache_assoc.sv
// Set-associative, multi-word-block instruction cache. Hits answer in the
// request cycle from the array; misses fetch the whole block starting at
// word 0 and the request then hits from the array.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    // datapath side
    input  logic  imemREN,
    input  word_t imemaddr,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  logic  halt,
    output logic  ihit,
    output word_t imemload,
    // memory side
    input  logic  iwait,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr
);

    localparam int BO  = $clog2(WORDS);
    localparam int BOW = idx_width(WORDS);
    localparam int IX  = $clog2(SETS);
    localparam int TW  = 30 - BO - IX;
    localparam int WW  = idx_width(WAYS);

    // line storage
    logic          valid_r [SETS][WAYS];
    logic [TW-1:0] tag_r   [SETS][WAYS];
    word_t         data_r  [SETS][WAYS][WORDS];

    // fill control
    icache_state_t state_r;
    logic [BOW-1:0] wcnt_r;
    word_t          base_r;
    logic [IX-1:0]  fset_r;
    logic [WW-1:0]  fway_r;
    logic           iren_r;
    word_t          iaddr_r;

    // request decode
    logic           req_s;
    logic [IX-1:0]  rset_s;
    logic [TW-1:0]  rtag_s;
    logic [BOW-1:0] rword_s;
    word_t          blk_base_s;

    logic           hit_any_s;
    logic [WW-1:0]  hit_way_s;
    logic           hit_s;
    logic           miss_s;
    logic           fill_we_s;
    logic           fill_last_s;

    logic [IX-1:0]   lru_set_s;
    logic [WAYS-1:0] set_valid_s;
    logic [WW-1:0]   lru_way_s;
    logic            lru_update_s;
    logic [WW-1:0]   victim_s;

    assign req_s      = imemREN & ~dmemREN & ~dmemWEN & ~halt;
    assign rset_s     = imemaddr[2+BO +: IX];
    assign rtag_s     = imemaddr[31 -: TW];
    assign rword_s    = (WORDS > 1) ? imemaddr[2 +: BOW] : '0;
    assign blk_base_s = imemaddr & ~word_t'(WORDS * 4 - 1);

    // Tag compare across the ways of the requested set.
    always_comb begin
        hit_any_s = 1'b0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any_s && valid_r[rset_s][w] && (tag_r[rset_s][w] == rtag_s)) begin
                hit_any_s = 1'b1;
                hit_way_s = WW'(w);
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    assign hit_s       = req_s & (state_r == IDLE) & hit_any_s;
    assign miss_s      = req_s & (state_r == IDLE) & ~hit_any_s;
    assign fill_we_s   = (state_r == FILL) & ~iwait;
    assign fill_last_s = fill_we_s & (wcnt_r == BOW'(WORDS - 1));

    // Datapath response: addressed word on a hit, zero otherwise.
    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        if (hit_s) begin
            ihit     = 1'b1;
            imemload = data_r[rset_s][hit_way_s][rword_s];
        end else begin
            ihit     = 1'b0;
            imemload = '0;
        end
    end

    // LRU port: the fill set while filling, the request set otherwise.
    always_comb begin
        lru_set_s = rset_s;
        if (state_r == FILL) begin
            lru_set_s = fset_r;
        end else begin
            lru_set_s = rset_s;
        end
        for (int w = 0; w < WAYS; w++) begin
            set_valid_s[w] = valid_r[lru_set_s][w];
        end
    end

    assign lru_update_s = hit_s | fill_last_s;
    assign lru_way_s    = hit_s ? hit_way_s : fway_r;

    icache_assoc_lru #(
        .SETS (SETS),
        .WAYS (WAYS),
        .IXW  (IX),
        .WW   (WW)
    ) u_lru (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_idx    (lru_set_s),
        .set_valid  (set_valid_s),
        .way_idx    (lru_way_s),
        .update     (lru_update_s),
        .victim_way (victim_s)
    );

    // Fill FSM: latch the miss, then walk the block word by word.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
            wcnt_r  <= '0;
            base_r  <= '0;
            fset_r  <= '0;
            fway_r  <= '0;
            iren_r  <= 1'b0;
            iaddr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_s) begin
                        state_r <= FILL;
                        wcnt_r  <= '0;
                        base_r  <= blk_base_s;
                        fset_r  <= rset_s;
                        fway_r  <= victim_s;
                        iren_r  <= 1'b1;
                        iaddr_r <= blk_base_s;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        if (wcnt_r == BOW'(WORDS - 1)) begin
                            state_r <= IDLE;
                            wcnt_r  <= '0;
                            iren_r  <= 1'b0;
                            iaddr_r <= '0;
                        end else begin
                            wcnt_r  <= wcnt_r + BOW'(1);
                            iaddr_r <= iaddr_r + 32'd4;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wcnt_r  <= '0;
                    iren_r  <= 1'b0;
                    iaddr_r <= '0;
                end
            endcase
        end
    end

    // Line storage: victim invalidated at miss, words written as they arrive,
    // tag and valid written with the last word.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w] <= 1'b0;
                    tag_r[s][w]   <= '0;
                    for (int k = 0; k < WORDS; k++) begin
                        data_r[s][w][k] <= '0;
                    end
                end
            end
        end else begin
            if (miss_s) begin
                valid_r[rset_s][victim_s] <= 1'b0;
            end
            if (fill_we_s) begin
                data_r[fset_r][fway_r][wcnt_r] <= iload;
            end
            if (fill_last_s) begin
                tag_r[fset_r][fway_r]   <= base_r[31 -: TW];
                valid_r[fset_r][fway_r] <= 1'b1;
            end
        end
    end

    assign iREN  = iren_r;
    assign iaddr = iaddr_r;

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (SETS=8, WAYS=2, WORDS=2) with a
// block/recency reference model and a variable-latency memory model.
module tb_icache_assoc;

    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int WORDS = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int mem_lat = 1;
    int mcnt = 0;

    typedef struct {
        logic        hit;
        logic        iren;
        logic        chk_load;
        logic [31:0] load;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] fetchq[$];

    // reference model: block base address and last-use stamp per way
    logic        m_valid [SETS][WAYS];
    logic [31:0] m_blk   [SETS][WAYS];
    longint      m_stamp [SETS][WAYS];
    longint      now_stamp = 0;

    icache_assoc #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .halt(halt), .ihit(ihit), .imemload(imemload),
        .iwait(iwait), .iload(iload), .iREN(iREN), .iaddr(iaddr)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hAAAA_0000;
        else if (a == 32'h0000_0044) return 32'hAAAA_0004;
        else return a ^ 32'h5C3A_9E00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory: iwait drops after mem_lat cycles per word, data from mem_word
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            iwait = !(iREN && (mcnt >= mem_lat - 1));
            iload = mem_word(iaddr);
        end
    end

    // fetch scoreboard: every accepted word must be the next expected address
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1 && iREN === 1'b1 && iwait === 1'b0) begin
                if (fetchq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_fetch: got iaddr %h expected no fetch at %0t", iaddr, $time);
                end else begin
                    check("fetch_addr", iaddr, fetchq.pop_front());
                end
                mcnt = 0;
            end else if (iREN === 1'b1) begin
                mcnt++;
            end else begin
                mcnt = 0;
            end
        end
    end

    // response monitor: one expectation record per driven cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("ihit", 32'(ihit), 32'(e.hit));
                check("iREN", 32'(iREN), 32'(e.iren));
                if (e.chk_load) check("imemload", imemload, e.load);
                if (!e.iren) check("iaddr_idle", iaddr, 32'h0);
            end
        end
    end

    task automatic drive_cycle(input logic rst_v, input logic ren, input logic dren,
                               input logic dwen, input logic hlt, input logic [31:0] a,
                               input logic e_hit, input logic e_iren, input logic e_chk,
                               input logic [31:0] e_load);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = rst_v; imemREN = ren; dmemREN = dren; dmemWEN = dwen; halt = hlt; imemaddr = a;
        e.hit = e_hit; e.iren = e_iren; e.chk_load = e_chk; e.load = e_load;
        expq.push_back(e);
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_blk[s][w]   = 32'h0;
                m_stamp[s][w] = 0;
            end
    endtask

    // mode 0: request held during fill; 1: random junk on the d-side/request
    // during fill; 2: halt raised during fill and for one cycle after it
    task automatic access(input logic [31:0] a, input int lat, input int mode);
        logic [31:0] bsz, blk;
        int s, w, v;
        bit hit;
        bsz = 32'(WORDS * 4);
        blk = a - (a % bsz);
        s   = int'((a / bsz) % 32'(SETS));
        hit = 1'b0;
        w   = 0;
        for (int i = 0; i < WAYS; i++)
            if (m_valid[s][i] && m_blk[s][i] == blk) begin hit = 1'b1; w = i; end
        if (hit) begin
            now_stamp++;
            m_stamp[s][w] = now_stamp;
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b1, 1'b0, 1'b1, mem_word(a & ~32'd3));
        end else begin
            v = -1;
            for (int i = 0; i < WAYS; i++)
                if (!m_valid[s][i] && v < 0) v = i;
            if (v < 0) begin
                v = 0;
                for (int i = 1; i < WAYS; i++)
                    if (m_stamp[s][i] < m_stamp[s][v]) v = i;
            end
            mem_lat = lat;
            for (int k = 0; k < WORDS; k++) fetchq.push_back(blk + 32'(4 * k));
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b0, 1'b0, 1'b0, 32'h0);
            for (int c = 0; c < WORDS * lat; c++) begin
                if (mode == 1)
                    drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
                else if (mode == 2)
                    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, 1'b0, 1'b1, 1'b0, 32'h0);
                else
                    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b0, 1'b1, 1'b0, 32'h0);
            end
            m_valid[s][v] = 1'b1;
            m_blk[s][v]   = blk;
            if (mode == 2)
                drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, 1'b0, 1'b0, 1'b1, 32'h0);
            now_stamp++;
            m_stamp[s][v] = now_stamp;
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b1, 1'b0, 1'b1, mem_word(a & ~32'd3));
        end
    endtask

    initial begin
        logic [31:0] a;
        int r;
        model_reset();

        // reset state
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);

        // cold miss with two cycles per word, then the other word hits
        access(32'h40, 2, 0);
        access(32'h44, 1, 0);

        // conflict in set 0, both lines resident
        access(32'h240, 1, 0);
        access(32'h40, 1, 0);
        access(32'h244, 1, 0);

        // LRU: touch 0x40, 0x440 evicts 0x240
        access(32'h40, 1, 0);
        access(32'h440, 1, 0);
        access(32'h40, 1, 0);
        access(32'h240, 1, 0);

        // halt with a missing address: nothing happens
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h840, 1'b0, 1'b0, 1'b1, 32'h0);

        // halt raised mid-fill: fill completes
        access(32'h884, 2, 2);

        // d-port activity masks a hit; hit returns the cycle it drops
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h880, 1'b0, 1'b0, 1'b1, 32'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h880, 1'b0, 1'b0, 1'b1, 32'h0);
        access(32'h880, 1, 0);

        // random traffic over a few competing blocks in sets 0 and 1
        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 1)) << 3) |
                (32'($urandom_range(0, 1)) << 2) | (32'($urandom_range(0, 1)) << 28) |
                32'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0)
                drive_cycle(1'b1, 1'b1, 1'b1, 1'($urandom), 1'b0, a, 1'b0, 1'b0, 1'b1, 32'h0);
            else if (r == 1)
                drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, 1'b0, 1'b0, 1'b1, 32'h0);
            else if (r == 2)
                drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, 1'b0, 1'b0, 1'b1, 32'h0);
            else
                access(a, $urandom_range(1, 3), $urandom_range(0, 1));
        end

        // reset during fill after word 0
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        model_reset();
        mem_lat = 1;
        fetchq.push_back(32'h40);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
        model_reset();
        access(32'h40, 1, 0);
        access(32'h44, 1, 0);

        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        repeat (3) @(posedge CLK);
        check("exp_queue_drained", 32'(expq.size()), 32'h0);
        check("fetch_queue_drained", 32'(fetchq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
